// File: rtl/ahb_lite_master_if.sv
// Command/response handshake and AHB-Lite master bus signals of ahb_lite_master.
// The master modport is the initiator's view; slave is the view of the agent and bus around it.
interface ahb_lite_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] ahb_haddr_o;
    logic        ahb_hwrite_o;
    logic [2:0]  ahb_hsize_o;
    logic [2:0]  ahb_hburst_o;
    logic [3:0]  ahb_hprot_o;
    logic [1:0]  ahb_htrans_o;
    logic        ahb_hmastlock_o;
    logic [31:0] ahb_hwdata_o;
    logic        ahb_hready_i;
    logic        ahb_hresp_i;
    logic [31:0] ahb_hrdata_i;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
               ahb_hready_i, ahb_hresp_i, ahb_hrdata_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               ahb_haddr_o, ahb_hwrite_o, ahb_hsize_o, ahb_hburst_o, ahb_hprot_o,
               ahb_htrans_o, ahb_hmastlock_o, ahb_hwdata_o
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
               ahb_hready_i, ahb_hresp_i, ahb_hrdata_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               ahb_haddr_o, ahb_hwrite_o, ahb_hsize_o, ahb_hburst_o, ahb_hprot_o,
               ahb_htrans_o, ahb_hmastlock_o, ahb_hwdata_o
    );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: turns valid/ready commands into SINGLE
// transfers with wait-state, ERROR-response and bus-hang timeout handling.
module ahb_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
    input  logic              clk,
    input  logic              resetn,
    ahb_lite_master_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [15:0] TMO_LAST      = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        cmd_legal;
    logic        tmo_hit;

    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            3'd0:    return 1'b1;
            3'd1:    return ~addr_lo[0];
            3'd2:    return addr_lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        htrans_d      = htrans_q;
        haddr_d       = haddr_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hwdata_d      = hwdata_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_rdata_d   = rsp_rdata_q;
        tmo_cnt_d     = tmo_cnt_q;
        cmd_legal     = is_legal(bus.cmd_size, bus.cmd_addr[1:0]);
        tmo_hit       = !bus.ahb_hready_i && (tmo_cnt_q == TMO_LAST);

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_legal) begin
                        state_d   = S_ADDR;
                        htrans_d  = HTRANS_NONSEQ;
                        haddr_d   = bus.cmd_addr;
                        hwrite_d  = bus.cmd_write;
                        hsize_d   = bus.cmd_size;
                        wdata_d   = bus.cmd_wdata;
                        tmo_cnt_d = '0;
                    end else begin
                        // Rejected commands answer without touching the bus.
                        state_d       = S_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_rdata_d   = '0;
                    end
                end
            end
            S_ADDR: begin
                if (bus.ahb_hready_i) begin
                    state_d   = S_DATA;
                    htrans_d  = HTRANS_IDLE;
                    tmo_cnt_d = '0;
                    if (hwrite_q) hwdata_d = wdata_q;
                end else if (tmo_hit) begin
                    state_d       = S_RESP;
                    htrans_d      = HTRANS_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                // A two-cycle ERROR just looks like a wait state followed by completion.
                if (bus.ahb_hready_i) begin
                    state_d       = S_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = bus.ahb_hresp_i;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!hwrite_q && !bus.ahb_hresp_i) ? bus.ahb_hrdata_i : '0;
                end else if (tmo_hit) begin
                    state_d       = S_RESP;
                    htrans_d      = HTRANS_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            htrans_q      <= HTRANS_IDLE;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= '0;
            hwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            htrans_q      <= htrans_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            hwdata_q      <= hwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    // Captured write data is only consumed after a legal accept, so it needs no reset.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    assign bus.cmd_ready       = (state_q == S_IDLE);
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rsp_rdata_q;
    assign bus.rsp_err         = rsp_err_q;
    assign bus.rsp_timeout     = rsp_timeout_q;
    assign bus.ahb_haddr_o     = haddr_q;
    assign bus.ahb_hwrite_o    = hwrite_q;
    assign bus.ahb_hsize_o     = hsize_q;
    assign bus.ahb_hburst_o    = 3'b000;
    assign bus.ahb_hprot_o     = HPROT_VAL;
    assign bus.ahb_htrans_o    = htrans_q;
    assign bus.ahb_hmastlock_o = 1'b0;
    assign bus.ahb_hwdata_o    = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: a cycle-driven AHB slave plus a latency/response
// model derived from the transfer rules, exercised by directed and random commands.
`timescale 1ns/1ps
module tb_ahb_lite_master;
    localparam int T = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    ahb_lite_master_if bus ();

    ahb_lite_master #(.TIMEOUT_CYCLES(T), .HPROT_VAL(4'b0011)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_hwdata;

    int          o_lat, o_nonseq, o_addr_bad, o_hold_bad;
    logic        o_data_seen, o_err, o_to, o_vld_after, o_rdy_after, o_rdy_before;
    logic [31:0] o_hwdata, o_rdata;

    // Expected outcome of one command, from the transfer rules; also tracks the held hwdata.
    function automatic void model(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                  input logic [31:0] wdata, input logic [31:0] rd, input int aw,
                                  input int dw, input logic err, input logic stuck,
                                  output int lat, output int nonseq, output logic e_err,
                                  output logic e_to, output logic [31:0] e_rdata,
                                  output logic dp, output logic [31:0] e_hwdata);
        logic legal;
        legal = (size <= 3'd2) && ((addr % (32'd1 << size)) == 32'd0);
        if (!legal)        begin lat = 1;           nonseq = 0;      e_err = 1'b1; e_to = 1'b0; dp = 1'b0; end
        else if (aw >= T)  begin lat = 1 + T;       nonseq = T;      e_err = 1'b1; e_to = 1'b1; dp = 1'b0; end
        else if (stuck)    begin lat = 2 + aw + T;  nonseq = aw + 1; e_err = 1'b1; e_to = 1'b1; dp = 1'b1; end
        else               begin lat = 3 + aw + dw; nonseq = aw + 1; e_err = err;  e_to = 1'b0; dp = 1'b1; end
        e_rdata = (legal && aw < T && !stuck && !err && !wr) ? rd : 32'h0;
        if (dp && wr) last_hwdata = wdata;
        e_hwdata = last_hwdata;
    endfunction

    // Issue one command, play the slave, then hold rsp_ready low for 'hold' cycles and consume.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input logic [31:0] rd, input int aw,
                          input int dw, input logic err, input logic stuck, input int hold);
        int   ph, cnt;
        logic done;
        o_lat = -1; o_nonseq = 0; o_addr_bad = 0; o_hold_bad = 0; o_data_seen = 1'b0;
        o_hwdata = '0; o_rdata = '0; o_err = 1'b0; o_to = 1'b0; o_vld_after = 1'b1; o_rdy_after = 1'b0;
        @(negedge clk);
        o_rdy_before = bus.cmd_ready;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_size = size;
        bus.cmd_wdata = wdata; bus.rsp_ready = 1'b0; bus.ahb_hready_i = 1'b1; bus.ahb_hresp_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom; bus.cmd_write = ~wr;
        ph = 0; cnt = 0; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (bus.ahb_htrans_o == 2'b10) begin
                o_nonseq++;
                if (bus.ahb_haddr_o !== addr || bus.ahb_hwrite_o !== wr || bus.ahb_hsize_o !== size)
                    o_addr_bad++;
            end
            if (bus.rsp_valid === 1'b1) begin
                o_lat = k + 1;
                done  = 1'b1;
            end else begin
                if (ph == 1 && !o_data_seen) begin o_data_seen = 1'b1; o_hwdata = bus.ahb_hwdata_o; end
                bus.ahb_hresp_i = 1'b0; bus.ahb_hrdata_i = $urandom;
                case (ph)
                    0: if (bus.ahb_htrans_o == 2'b10 && cnt < aw) begin
                           bus.ahb_hready_i = 1'b0; cnt++;
                       end else begin
                           bus.ahb_hready_i = 1'b1;
                           if (bus.ahb_htrans_o == 2'b10) begin ph = 1; cnt = 0; end
                       end
                    1: if (stuck) bus.ahb_hready_i = 1'b0;
                       else if (cnt < dw) begin
                           bus.ahb_hready_i = 1'b0; bus.ahb_hresp_i = err && (cnt == dw - 1); cnt++;
                       end else begin
                           bus.ahb_hready_i = 1'b1; bus.ahb_hresp_i = err; bus.ahb_hrdata_i = rd; ph = 2;
                       end
                    default: bus.ahb_hready_i = 1'b1;
                endcase
                @(negedge clk);
            end
        end
        if (done) begin
            o_rdata = bus.rsp_rdata; o_err = bus.rsp_err; o_to = bus.rsp_timeout;
            bus.ahb_hready_i = 1'b1; bus.ahb_hresp_i = 1'b0;
            for (int h = 0; h < hold; h++) begin
                bus.ahb_hrdata_i = $urandom;
                @(negedge clk);
                if (bus.ahb_htrans_o == 2'b10) o_nonseq++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o_rdata || bus.rsp_err !== o_err ||
                    bus.rsp_timeout !== o_to || bus.cmd_ready !== 1'b0) o_hold_bad++;
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            if (bus.ahb_htrans_o == 2'b10) o_nonseq++;
            o_vld_after = bus.rsp_valid; o_rdy_after = bus.cmd_ready;
        end else begin
            // Response never came: recover the DUT so later scenarios still run.
            resetn = 1'b0; bus.ahb_hready_i = 1'b1;
            @(negedge clk);
            resetn = 1'b1; last_hwdata = '0;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_size = '0;
        bus.cmd_wdata = '0; bus.rsp_ready = 1'b0; bus.ahb_hready_i = 1'b1; bus.ahb_hresp_i = 1'b0;
        bus.ahb_hrdata_i = '0; last_hwdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ahb_htrans_o !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b want 00", bus.ahb_htrans_o); end
        checks++; if (bus.ahb_haddr_o !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %h want 0", bus.ahb_haddr_o); end
        checks++; if ({bus.ahb_hwrite_o, bus.ahb_hsize_o} !== 4'h0) begin errors++; $display("FAIL reset_hwrite_hsize: got %h want 0", {bus.ahb_hwrite_o, bus.ahb_hsize_o}); end
        checks++; if (bus.ahb_hwdata_o !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %h want 0", bus.ahb_hwdata_o); end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags: got %b want 000", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if ({bus.ahb_hburst_o, bus.ahb_hprot_o, bus.ahb_hmastlock_o} !== {3'b000, 4'b0011, 1'b0}) begin errors++; $display("FAIL reset_constants: got %b want 00000110", {bus.ahb_hburst_o, bus.ahb_hprot_o, bus.ahb_hmastlock_o}); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.ahb_htrans_o !== 2'b00) begin errors++; $display("FAIL reset_release: got ready=%b htrans=%b want 1/00", bus.cmd_ready, bus.ahb_htrans_o); end
    endtask

    task automatic test_write_zero_wait();
        int lat, ns; logic ee, et, dp; logic [31:0] er, eh;
        model(1'b1, 32'h104, 3'd2, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 1'b0, lat, ns, ee, et, er, dp, eh);
        do_txn(1'b1, 32'h104, 3'd2, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 1'b0, 0);
        checks++; if (o_lat !== lat) begin errors++; $display("FAIL wr0_latency: got %0d want %0d", o_lat, lat); end
        checks++; if (o_nonseq !== ns || o_addr_bad !== 0) begin errors++; $display("FAIL wr0_nonseq: got %0d (bad addr %0d) want %0d", o_nonseq, o_addr_bad, ns); end
        checks++; if (o_hwdata !== eh) begin errors++; $display("FAIL wr0_hwdata: got %h want %h", o_hwdata, eh); end
        checks++; if (o_err !== ee || o_rdata !== er) begin errors++; $display("FAIL wr0_rsp: got err=%b rdata=%h want %b/%h", o_err, o_rdata, ee, er); end
    endtask

    task automatic test_read_wait();
        int lat, ns; logic ee, et, dp; logic [31:0] er, eh;
        model(1'b0, 32'h200, 3'd2, 32'h0, 32'h12345678, 0, 2, 1'b0, 1'b0, lat, ns, ee, et, er, dp, eh);
        do_txn(1'b0, 32'h200, 3'd2, 32'h0, 32'h12345678, 0, 2, 1'b0, 1'b0, 1);
        checks++; if (o_lat !== lat) begin errors++; $display("FAIL rdwait_latency: got %0d want %0d", o_lat, lat); end
        checks++; if (o_rdata !== er || o_err !== ee) begin errors++; $display("FAIL rdwait_rsp: got rdata=%h err=%b want %h/%b", o_rdata, o_err, er, ee); end
        checks++; if (o_addr_bad !== 0 || o_nonseq !== ns) begin errors++; $display("FAIL rdwait_addr: got nonseq=%0d bad=%0d want %0d/0", o_nonseq, o_addr_bad, ns); end
        checks++; if (o_hwdata !== eh) begin errors++; $display("FAIL rdwait_hwdata_held: got %h want %h", o_hwdata, eh); end
    endtask

    task automatic test_two_cycle_error();
        int lat, ns; logic ee, et, dp; logic [31:0] er, eh;
        model(1'b0, 32'hFFC, 3'd2, 32'h0, 32'hA5A5A5A5, 0, 1, 1'b1, 1'b0, lat, ns, ee, et, er, dp, eh);
        do_txn(1'b0, 32'hFFC, 3'd2, 32'h0, 32'hA5A5A5A5, 0, 1, 1'b1, 1'b0, 2);
        checks++; if (o_lat !== lat) begin errors++; $display("FAIL err_latency: got %0d want %0d", o_lat, lat); end
        checks++; if (o_err !== ee || o_to !== et || o_rdata !== er) begin errors++; $display("FAIL err_rsp: got err=%b to=%b rdata=%h want %b/%b/%h", o_err, o_to, o_rdata, ee, et, er); end
        checks++; if (o_nonseq !== ns) begin errors++; $display("FAIL err_single_nonseq: got %0d want %0d", o_nonseq, ns); end
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [2];
        logic [2:0]  sizes [2];
        int lat, ns; logic ee, et, dp; logic [31:0] er, eh;
        addrs[0] = 32'h102; sizes[0] = 3'd2;
        addrs[1] = 32'h100; sizes[1] = 3'd3;
        for (int i = 0; i < 2; i++) begin
            model(1'b0, addrs[i], sizes[i], 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, lat, ns, ee, et, er, dp, eh);
            do_txn(1'b0, addrs[i], sizes[i], 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 1);
            checks++; if (o_lat !== lat) begin errors++; $display("FAIL illegal%0d_latency: got %0d want %0d", i, o_lat, lat); end
            checks++; if (o_nonseq !== ns) begin errors++; $display("FAIL illegal%0d_no_bus: got %0d NONSEQ cycles want %0d", i, o_nonseq, ns); end
            checks++; if (o_err !== ee || o_to !== et || o_rdata !== er) begin errors++; $display("FAIL illegal%0d_rsp: got err=%b to=%b rdata=%h want %b/%b/%h", i, o_err, o_to, o_rdata, ee, et, er); end
        end
    endtask

    task automatic test_timeout();
        int lat, ns; logic ee, et, dp; logic [31:0] er, eh, rd;
        model(1'b0, 32'h400, 3'd2, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1, lat, ns, ee, et, er, dp, eh);
        do_txn(1'b0, 32'h400, 3'd2, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1, 3);
        checks++; if (o_lat !== lat) begin errors++; $display("FAIL tmo_data_latency: got %0d want %0d", o_lat, lat); end
        checks++; if (o_err !== ee || o_to !== et || o_rdata !== er) begin errors++; $display("FAIL tmo_data_rsp: got err=%b to=%b rdata=%h want %b/%b/%h", o_err, o_to, o_rdata, ee, et, er); end
        checks++; if (o_hold_bad !== 0 || o_nonseq !== ns) begin errors++; $display("FAIL tmo_late_hready: got %0d unstable cycles, %0d NONSEQ want 0/%0d", o_hold_bad, o_nonseq, ns); end
        model(1'b1, 32'h408, 3'd1, 32'h11112222, 32'h0, T, 0, 1'b0, 1'b0, lat, ns, ee, et, er, dp, eh);
        do_txn(1'b1, 32'h408, 3'd1, 32'h11112222, 32'h0, T, 0, 1'b0, 1'b0, 0);
        checks++; if (o_lat !== lat || o_nonseq !== ns) begin errors++; $display("FAIL tmo_addr: got lat=%0d nonseq=%0d want %0d/%0d", o_lat, o_nonseq, lat, ns); end
        checks++; if (o_err !== ee || o_to !== et) begin errors++; $display("FAIL tmo_addr_rsp: got err=%b to=%b want %b/%b", o_err, o_to, ee, et); end
        rd = $urandom;
        model(1'b0, 32'h404, 3'd2, 32'h0, rd, 0, 1, 1'b0, 1'b0, lat, ns, ee, et, er, dp, eh);
        do_txn(1'b0, 32'h404, 3'd2, 32'h0, rd, 0, 1, 1'b0, 1'b0, 0);
        checks++; if (o_lat !== lat || o_rdata !== er || o_err !== ee || o_to !== et) begin errors++; $display("FAIL tmo_recover: got lat=%0d rdata=%h err=%b to=%b want %0d/%h/%b/%b", o_lat, o_rdata, o_err, o_to, lat, er, ee, et); end
    endtask

    task automatic test_random();
        int lat, ns, aw, dw, hold; logic ee, et, dp, wr, err, stuck; logic [31:0] er, eh, addr, wd, rd, r;
        logic [2:0] size;
        for (int n = 0; n < 40; n++) begin
            r = $urandom; wr = r[0];
            size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            addr = {r[31:2], 2'b00};
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wd = $urandom; rd = $urandom;
            aw = $urandom_range(0, 3); dw = $urandom_range(0, 4);
            err = ($urandom_range(0, 4) == 0); if (err && dw == 0) dw = 1;
            stuck = ($urandom_range(0, 9) == 0); hold = $urandom_range(0, 3);
            model(wr, addr, size, wd, rd, aw, dw, err, stuck, lat, ns, ee, et, er, dp, eh);
            do_txn(wr, addr, size, wd, rd, aw, dw, err, stuck, hold);
            checks++; if (o_rdy_before !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready: got %b want 1", n, o_rdy_before); end
            checks++; if (o_lat !== lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, o_lat, lat); end
            checks++; if (o_nonseq !== ns || o_addr_bad !== 0) begin errors++; $display("FAIL rnd%0d_nonseq: got %0d (bad %0d) want %0d", n, o_nonseq, o_addr_bad, ns); end
            checks++; if (o_err !== ee || o_to !== et) begin errors++; $display("FAIL rnd%0d_flags: got err=%b to=%b want %b/%b", n, o_err, o_to, ee, et); end
            checks++; if (o_rdata !== er) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h", n, o_rdata, er); end
            if (dp) begin
                checks++; if (o_hwdata !== eh) begin errors++; $display("FAIL rnd%0d_hwdata: got %h want %h", n, o_hwdata, eh); end
            end
            checks++; if (o_hold_bad !== 0) begin errors++; $display("FAIL rnd%0d_hold: got %0d unstable cycles want 0", n, o_hold_bad); end
            checks++; if (o_vld_after !== 1'b0 || o_rdy_after !== 1'b1) begin errors++; $display("FAIL rnd%0d_release: got valid=%b ready=%b want 0/1", n, o_vld_after, o_rdy_after); end
        end
    endtask

    task automatic test_backpressure_reset();
        int lat, ns; logic ee, et, dp; logic [31:0] er, eh, wd, rd;
        wd = $urandom;
        model(1'b1, 32'h500, 3'd2, wd, 32'h0, 1, 1, 1'b0, 1'b0, lat, ns, ee, et, er, dp, eh);
        do_txn(1'b1, 32'h500, 3'd2, wd, 32'h0, 1, 1, 1'b0, 1'b0, 10);
        checks++; if (o_hold_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", o_hold_bad); end
        checks++; if (o_vld_after !== 1'b0 || o_rdy_after !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", o_vld_after, o_rdy_after); end
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h600; bus.cmd_size = 3'd2;
        bus.cmd_wdata = $urandom; bus.ahb_hready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.ahb_htrans_o !== 2'b10 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_in_addr: got htrans=%b ready=%b want 10/0", bus.ahb_htrans_o, bus.cmd_ready); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (bus.ahb_htrans_o !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.ahb_haddr_o !== 32'h0) begin errors++; $display("FAIL rst_async: got htrans=%b valid=%b haddr=%h want 00/0/0", bus.ahb_htrans_o, bus.rsp_valid, bus.ahb_haddr_o); end
        @(negedge clk);
        resetn = 1'b1; bus.ahb_hready_i = 1'b1; last_hwdata = '0;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got ready=%b valid=%b want 1/0", bus.cmd_ready, bus.rsp_valid); end
        rd = $urandom;
        model(1'b0, 32'h604, 3'd2, 32'h0, rd, 0, 0, 1'b0, 1'b0, lat, ns, ee, et, er, dp, eh);
        do_txn(1'b0, 32'h604, 3'd2, 32'h0, rd, 0, 0, 1'b0, 1'b0, 0);
        checks++; if (o_lat !== lat || o_rdata !== er || o_hwdata !== eh) begin errors++; $display("FAIL rst_next_txn: got lat=%0d rdata=%h hwdata=%h want %0d/%h/%h", o_lat, o_rdata, o_hwdata, lat, er, eh); end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_two_cycle_error();
        test_illegal();
        test_timeout();
        test_random();
        test_backpressure_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
